// File: rtl/multi_port_fifo.sv
// Circular FIFO with ENQ_W enqueue lanes and DEQ_W dequeue lanes per cycle, in-order lanes.
// Optional synchronous flush input is built in when MPFIFO_FLUSH_EN is defined.
module multi_port_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int ENQ_W = 2,
    parameter int DEQ_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ENQ_W-1:0]           enq_valid,
    input  logic [ENQ_W*WIDTH-1:0]     enq_data,
    output logic [ENQ_W-1:0]           enq_ready,
    output logic [DEQ_W-1:0]           deq_valid,
    output logic [DEQ_W*WIDTH-1:0]     deq_data,
    input  logic [DEQ_W-1:0]           deq_ready,
    output logic [$clog2(DEPTH):0]     count
`ifdef MPFIFO_FLUSH_EN
    ,
    input  logic                       flush
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    typedef logic [PW-1:0] ptr_t;
    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t count_q, count_d;
    ptr_t n_enq, n_deq;
    ptr_t free_slots;
    logic flush_act;

`ifdef MPFIFO_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign count      = count_q;
    assign free_slots = DEPTH_P - count_q;

    // Handshake: a lane transfers when its valid and ready are both high and every lower
    // lane also transfers; the first lane that does not transfer ends the group. Ready
    // and valid depend only on start-of-cycle occupancy, so there is no pass-through.
    always_comb begin
        enq_ready = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            enq_ready[i] = free_slots > ptr_t'(i);
        end
    end

    always_comb begin
        logic [AW-1:0] rd_idx;
        rd_idx    = '0;
        deq_valid = '0;
        deq_data  = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            rd_idx       = head_q[AW-1:0] + AW'(i);
            deq_valid[i] = count_q > ptr_t'(i);
            deq_data[i*WIDTH +: WIDTH] = deq_valid[i] ? mem_q[rd_idx] : '0;
        end
    end

    always_comb begin
        logic run;
        run   = 1'b1;
        n_enq = '0;
        for (int i = 0; i < ENQ_W; i++) begin
            run   = run & enq_valid[i] & enq_ready[i];
            n_enq = n_enq + ptr_t'(run);
        end
    end

    always_comb begin
        logic run;
        run   = 1'b1;
        n_deq = '0;
        for (int i = 0; i < DEQ_W; i++) begin
            run   = run & deq_valid[i] & deq_ready[i];
            n_deq = n_deq + ptr_t'(run);
        end
    end

    // Pointers carry a wrap bit so the add wraps mod 2*DEPTH for free.
    always_comb begin
        head_d  = head_q + n_deq;
        tail_d  = tail_q + n_enq;
        count_d = count_q + n_enq - n_deq;
        if (flush_act) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!flush_act) begin
            for (int i = 0; i < ENQ_W; i++) begin
                if (ptr_t'(i) < n_enq) begin
                    mem_q[tail_q[AW-1:0] + AW'(i)] <= enq_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_port_fifo.sv
// Directed bench for multi_port_fifo at default parameters; data order tracked by a
// scoreboard queue, occupancy by hand-computed constants.
module tb_multi_port_fifo;
  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic [1:0]    enq_valid;
  logic [2*W-1:0] enq_data;
  logic [1:0]    enq_ready;
  logic [1:0]    deq_valid;
  logic [2*W-1:0] deq_data;
  logic [1:0]    deq_ready;
  logic [3:0]    count;
`ifdef MPFIFO_FLUSH_EN
  logic          flush;
`endif

  int checks;
  int failures;
  int mdl_cnt;
  logic [W-1:0] exp_q[$];

  multi_port_fifo #(.WIDTH(32), .DEPTH(8), .ENQ_W(2), .DEQ_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_data  (enq_data),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .deq_ready (deq_ready),
    .count     (count)
`ifdef MPFIFO_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    check("rst_count", 64'(count), 64'd0);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_enq_ready", 64'(enq_ready), 64'd3);
    check("rst_deq_data", 64'(deq_data), 64'd0);
    mdl_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // driver: one cycle of enq/deq traffic, checks against the model before the edge
  task automatic step(input logic [1:0] ev, input logic [W-1:0] d0, input logic [W-1:0] d1,
                      input logic [1:0] dr);
    logic [1:0] rdy_e;
    logic [1:0] val_e;
    logic [W-1:0] lane;
    logic [W-1:0] din;
    logic run;
    int pops;
    int pushes;
    enq_valid = ev;
    enq_data  = {d1, d0};
    deq_ready = dr;
    #1;
    for (int i = 0; i < 2; i++) begin
      rdy_e[i] = (8 - mdl_cnt) > i;
      val_e[i] = mdl_cnt > i;
    end
    check("enq_ready", 64'(enq_ready), 64'(rdy_e));
    check("deq_valid", 64'(deq_valid), 64'(val_e));
    check("count", 64'(count), 64'(mdl_cnt));
    run  = 1'b1;
    pops = 0;
    for (int i = 0; i < 2; i++) begin
      lane = deq_data[i*W +: W];
      if (!val_e[i]) check("deq_zero", 64'(lane), 64'd0);
      else if (exp_q.size() > i) check("deq_data", 64'(lane), 64'(exp_q[i]));
      run = run & val_e[i] & dr[i];
      if (run) pops++;
    end
    for (int i = 0; i < pops; i++) void'(exp_q.pop_front());
    run    = 1'b1;
    pushes = 0;
    for (int i = 0; i < 2; i++) begin
      run = run & ev[i] & rdy_e[i];
      din = (i == 0) ? d0 : d1;
      if (run) begin
        exp_q.push_back(din);
        pushes++;
      end
    end
    mdl_cnt = mdl_cnt + pushes - pops;
    @(posedge clk);
    #1;
    enq_valid = 2'b00;
    deq_ready = 2'b00;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    mdl_cnt   = 0;
    rst       = 1'b1;
    enq_valid = 2'b00;
    enq_data  = '0;
    deq_ready = 2'b00;
`ifdef MPFIFO_FLUSH_EN
    flush     = 1'b0;
`endif
    apply_reset();

    // gap on lane 0: nothing accepted
    step(2'b10, 32'hBAD0_0000, 32'hBAD0_0001, 2'b00);
    check("gap_count", 64'(count), 64'd0);
    check("gap_deq_valid", 64'(deq_valid), 64'd0);

    // fill to full, 2 per cycle
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 32'hA000_0000 + 32'(2*k), 32'hA000_0001 + 32'(2*k), 2'b00);
      check("fill_count", 64'(count), 64'(2*k + 2));
    end
    check("full_enq_ready", 64'(enq_ready), 64'd0);
    check("full_lane0", 64'(deq_data[W-1:0]), 64'h0A00_0000 << 4);
    check("full_lane1", 64'(deq_data[2*W-1:W]), 64'hA000_0001);

    // enqueue while full with a same-cycle dequeue: no pass-through
    step(2'b01, 32'hBAD0_0002, 32'hBAD0_0003, 2'b01);
    check("full_pass_count", 64'(count), 64'd7);

    // near-full: only lane 0 fits
    step(2'b11, 32'hC000_0000, 32'hC000_0001, 2'b00);
    check("nearfull_count", 64'(count), 64'd8);

    for (int k = 0; k < 4; k++) step(2'b00, '0, '0, 2'b11);
    check("drain_count", 64'(count), 64'd0);

    // tail wraps past entry 7 while enqueueing 2 and dequeueing 1 per cycle
    for (int k = 0; k < 5; k++) begin
      step(2'b11, 32'hD000_0000 + 32'(2*k), 32'hD000_0001 + 32'(2*k), 2'b01);
    end
    check("wrap_count", 64'(count), 64'd6);
    step(2'b11, 32'hE000_0000, 32'hE000_0001, 2'b11);
    check("simul_count", 64'(count), 64'd6);
    step(2'b00, '0, '0, 2'b10);
    check("deq_gap_count", 64'(count), 64'd6);
    for (int k = 0; k < 3; k++) step(2'b00, '0, '0, 2'b11);
    check("wrap_drain_count", 64'(count), 64'd0);

    // reset mid-operation discards contents
    step(2'b11, 32'hF000_0000, 32'hF000_0001, 2'b00);
    apply_reset();
    step(2'b01, 32'h1234_5678, 32'h0, 2'b00);
    check("post_rst_lane0", 64'(deq_data[W-1:0]), 64'h1234_5678);
    step(2'b00, '0, '0, 2'b01);

`ifdef MPFIFO_FLUSH_EN
    step(2'b11, 32'h5000_0000, 32'h5000_0001, 2'b00);
    step(2'b11, 32'h5000_0002, 32'h5000_0003, 2'b00);
    step(2'b01, 32'h5000_0004, 32'h5000_0005, 2'b00);
    check("pre_flush_count", 64'(count), 64'd5);
    enq_valid = 2'b11;
    enq_data  = {32'h6000_0001, 32'h6000_0000};
    flush     = 1'b1;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    enq_valid = 2'b00;
    mdl_cnt   = 0;
    exp_q.delete();
    check("flush_count", 64'(count), 64'd0);
    check("flush_deq_valid", 64'(deq_valid), 64'd0);
    step(2'b01, 32'hB000_0000, 32'h0, 2'b00);
    check("flush_b0", 64'(deq_data[W-1:0]), 64'hB000_0000);
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
